// File: rtl/xconf_bank.sv
// xconf_bank: double-buffered configuration bank.
// Host writes land in a shadow bank; COMMIT copies shadow to the active bank
// (conf_out) once the engine is idle. A small FSM streams whole shadow banks
// to and from an external config memory (SAVE / LOAD).
module xconf_bank #(
  parameter int N_FIELDS = 32,
  parameter int FIELD_W  = 16,
  parameter int DATA_W   = 32,
  parameter int N_SLOTS  = 8,
  parameter int ADDR_W   = 6,
  localparam int SLOT_W  = $clog2(N_SLOTS),
  localparam int IDX_W   = $clog2(N_FIELDS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req,
  input  logic                        rnw,
  input  logic [ADDR_W-1:0]           addr,
  input  logic [DATA_W-1:0]           data_in,
  output logic [DATA_W-1:0]           data_out,
  output logic                        ack,
  output logic                        ready,
  input  logic                        engine_busy,
  output logic                        commit_done,
  output logic [N_FIELDS*FIELD_W-1:0] conf_out,
  output logic                        cm_en,
  output logic                        cm_we,
  output logic [SLOT_W+IDX_W-1:0]     cm_addr,
  output logic [FIELD_W-1:0]          cm_wdata,
  input  logic [FIELD_W-1:0]          cm_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SAVE,
    S_LOAD_RD,
    S_LOAD_LAST
  } state_t;

  localparam logic [ADDR_W-1:0] A_CLEAR  = ADDR_W'(N_FIELDS);
  localparam logic [ADDR_W-1:0] A_COMMIT = ADDR_W'(N_FIELDS + 1);
  localparam logic [ADDR_W-1:0] A_SAVE   = ADDR_W'(N_FIELDS + 2);
  localparam logic [ADDR_W-1:0] A_LOAD   = ADDR_W'(N_FIELDS + 3);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(N_FIELDS + 4);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_FIELDS - 1);

  state_t             state;
  logic [SLOT_W-1:0]  slot;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   next_idx;
  logic [FIELD_W-1:0] shadow [N_FIELDS];
  logic [FIELD_W-1:0] active [N_FIELDS];
  logic               pending_commit;
  logic               rd_vld;
  logic [IDX_W-1:0]   rd_idx;

  logic               accept;
  logic               is_field;
  logic [IDX_W-1:0]   field_idx;
  logic               wr_field, wr_clear, wr_commit, wr_save, wr_load;
  logic               commit_fire;
  logic [SLOT_W-1:0]  cmd_slot;
  logic [DATA_W-1:0]  rd_value;

  assign ready       = (state == S_IDLE);
  assign accept      = req && ready;
  assign is_field    = (addr < ADDR_W'(N_FIELDS));
  assign field_idx   = addr[IDX_W-1:0];
  assign wr_field    = accept && !rnw && is_field;
  assign wr_clear    = accept && !rnw && (addr == A_CLEAR);
  assign wr_commit   = accept && !rnw && (addr == A_COMMIT);
  assign wr_save     = accept && !rnw && (addr == A_SAVE);
  assign wr_load     = accept && !rnw && (addr == A_LOAD);
  assign cmd_slot    = data_in[SLOT_W-1:0];
  assign next_idx    = idx + 1'b1;
  // The copy is held off while a transfer runs so a half-loaded bank never goes live.
  assign commit_fire = pending_commit && !engine_busy && ready;

  // Host data bits above the field width carry no information for this block.
  if (DATA_W > FIELD_W) begin : g_unused_hi
    logic unused_data_hi;
    assign unused_data_hi = ^data_in[DATA_W-1:FIELD_W];
  end

  // Read mux: shadow field, status word, or zero for unmapped addresses.
  always_comb begin
    // NOTE: default assignment first so no path leaves rd_value unassigned (no latch).
    rd_value = '0;
    if (is_field) begin
      rd_value = DATA_W'(shadow[field_idx]);
    end else if (addr == A_STATUS) begin
      rd_value = DATA_W'({pending_commit, ~ready});
    end
  end

  // Host response: ack pulses one cycle after acceptance, read data registered alongside.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      ack      <= 1'b0;
      data_out <= '0;
    end else begin
      ack <= accept;
      if (accept) begin
        data_out <= rnw ? rd_value : '0;
      end
    end
  end

  // Shadow bank: host writes, CLEAR, and field captures returning from a LOAD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: this bank is flops, not RAM, and must power up cleared, so it takes the reset.
      for (int k = 0; k < N_FIELDS; k++) shadow[k] <= '0;
    end else begin
      if (rd_vld) begin
        shadow[rd_idx] <= cm_rdata;
      end
      if (wr_field) begin
        shadow[field_idx] <= data_in[FIELD_W-1:0];
      end else if (wr_clear) begin
        for (int k = 0; k < N_FIELDS; k++) shadow[k] <= '0;
      end
    end
  end

  // Commit: pending flag, shadow-to-active copy and the commit_done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_commit <= 1'b0;
      commit_done    <= 1'b0;
      for (int k = 0; k < N_FIELDS; k++) active[k] <= '0;
    end else begin
      commit_done <= commit_fire;
      if (commit_fire) begin
        for (int k = 0; k < N_FIELDS; k++) active[k] <= shadow[k];
      end
      if (wr_commit) begin
        pending_commit <= 1'b1;
      end else if (commit_fire) begin
        pending_commit <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < N_FIELDS; g++) begin : g_conf
    assign conf_out[g*FIELD_W +: FIELD_W] = active[g];
  end

  // SAVE/LOAD sequencer with registered config-memory strobes and a
  // one-stage index pipeline matching the memory's read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      slot     <= '0;
      idx      <= '0;
      cm_en    <= 1'b0;
      cm_we    <= 1'b0;
      cm_addr  <= '0;
      cm_wdata <= '0;
      rd_vld   <= 1'b0;
      rd_idx   <= '0;
    end else begin
      rd_vld <= cm_en && !cm_we;
      rd_idx <= cm_addr[IDX_W-1:0];
      case (state)
        S_IDLE: begin
          if (wr_save) begin
            state    <= S_SAVE;
            slot     <= cmd_slot;
            idx      <= '0;
            cm_en    <= 1'b1;
            cm_we    <= 1'b1;
            cm_addr  <= {cmd_slot, {IDX_W{1'b0}}};
            cm_wdata <= shadow[0];
          end else if (wr_load) begin
            state   <= S_LOAD_RD;
            slot    <= cmd_slot;
            idx     <= '0;
            cm_en   <= 1'b1;
            cm_we   <= 1'b0;
            cm_addr <= {cmd_slot, {IDX_W{1'b0}}};
          end
        end
        S_SAVE: begin
          if (idx == LAST_IDX) begin
            state <= S_IDLE;
            cm_en <= 1'b0;
            cm_we <= 1'b0;
          end else begin
            idx      <= next_idx;
            cm_addr  <= {slot, next_idx};
            cm_wdata <= shadow[next_idx];
          end
        end
        S_LOAD_RD: begin
          if (idx == LAST_IDX) begin
            state <= S_LOAD_LAST;
            cm_en <= 1'b0;
          end else begin
            idx     <= next_idx;
            cm_addr <= {slot, next_idx};
          end
        end
        S_LOAD_LAST: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          cm_en <= 1'b0;
          cm_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xconf_bank.sv
// Self-checking bench for xconf_bank: table-driven host vectors, directed
// multi-cycle sequences and a randomized phase against a behavioural model.
module tb_xconf_bank;

  localparam int NF = 32;
  localparam int FW = 16;
  localparam int DW = 32;
  localparam int NS = 8;
  localparam int AW = 6;
  localparam int SW = 3;
  localparam int IW = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic           req;
  logic           rnw;
  logic [AW-1:0]  addr;
  logic [DW-1:0]  data_in;
  logic [DW-1:0]  data_out;
  logic           ack;
  logic           ready;
  logic           engine_busy;
  logic           commit_done;
  logic [NF*FW-1:0] conf_out;
  logic           cm_en;
  logic           cm_we;
  logic [SW+IW-1:0] cm_addr;
  logic [FW-1:0]  cm_wdata;
  logic [FW-1:0]  cm_rdata;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  logic [FW-1:0] mem   [NS*NF];
  logic [FW-1:0] sh_m  [NF];
  logic [FW-1:0] act_m [NF];
  bit            pend_m;

  xconf_bank #(
    .N_FIELDS(NF), .FIELD_W(FW), .DATA_W(DW), .N_SLOTS(NS), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .rnw(rnw), .addr(addr),
    .data_in(data_in), .data_out(data_out), .ack(ack), .ready(ready),
    .engine_busy(engine_busy), .commit_done(commit_done), .conf_out(conf_out),
    .cm_en(cm_en), .cm_we(cm_we), .cm_addr(cm_addr), .cm_wdata(cm_wdata),
    .cm_rdata(cm_rdata)
  );

  always #5 clk = ~clk;

  // External config memory, one-cycle read latency
  always @(posedge clk) begin
    if (cm_en) begin
      if (cm_we) mem[cm_addr] <= cm_wdata;
      else       cm_rdata     <= mem[cm_addr];
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_conf(input string name);
    logic [NF*FW-1:0] e;
    for (int k = 0; k < NF; k++) e[k*FW +: FW] = act_m[k];
    n_checks++;
    if (conf_out !== e) begin
      n_errors++;
      $display("FAIL %s: conf_out=%h expected %h", name, conf_out, e);
    end
  endtask

  // One host transaction; called and returns at a negedge, ack sampled there.
  task automatic host(input bit r, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      output logic [DW-1:0] q);
    int n;
    n = 0;
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL host_wait: ready=0 after %0d cycles, expected 1", n);
    end
    req = 1'b1; rnw = r; addr = a; data_in = d;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    check($sformatf("ack_addr%0d", a), ack, 1);
    q = data_out;
  endtask

  // One model clock edge with the engine idle state given: pending commit, then the host op.
  function automatic bit model_edge(input int op, input int a, input logic [FW-1:0] d);
    bit fire;
    fire = pend_m && !engine_busy;
    if (fire) act_m = sh_m;
    case (op)
      1: sh_m[a] = d;
      2: for (int k = 0; k < NF; k++) sh_m[k] = '0;
      default: ;
    endcase
    if (op == 3) pend_m = 1'b1;
    else if (fire) pend_m = 1'b0;
    return fire;
  endfunction

  typedef struct {
    bit            rnw;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            chk;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [DW-1:0] q;
    logic [FW-1:0] rv [NF];
    int n;
    int bad;

    vecs[0] = '{1'b0, 6'd3,  32'h0000_1234, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 6'd3,  32'h0,         1'b1, 32'h0000_1234};
    vecs[2] = '{1'b0, 6'd31, 32'hABCD_BEEF, 1'b0, 32'h0};
    vecs[3] = '{1'b1, 6'd31, 32'h0,         1'b1, 32'h0000_BEEF};
    vecs[4] = '{1'b1, 6'd0,  32'h0,         1'b1, 32'h0};
    vecs[5] = '{1'b1, 6'd36, 32'h0,         1'b1, 32'h0};
    vecs[6] = '{1'b1, 6'd37, 32'h0,         1'b1, 32'h0};
    vecs[7] = '{1'b0, 6'd63, 32'h0000_FFFF, 1'b0, 32'h0};
    vecs[8] = '{1'b1, 6'd63, 32'h0,         1'b1, 32'h0};
    vecs[9] = '{1'b1, 6'd3,  32'h0,         1'b1, 32'h0000_1234};

    rst = 1'b1; req = 1'b0; rnw = 1'b0; addr = '0; data_in = '0; engine_busy = 1'b0;
    for (int k = 0; k < NF; k++) begin sh_m[k] = '0; act_m[k] = '0; end
    pend_m = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_ack", ack, 0);
    check("rst_data_out", data_out, 0);
    check("rst_cm_en", cm_en, 0);
    check("rst_commit_done", commit_done, 0);
    check_conf("rst_conf");
    rst = 1'b0;
    @(negedge clk);

    // Table-driven host accesses
    for (int i = 0; i < 10; i++) begin
      host(vecs[i].rnw, vecs[i].addr, vecs[i].data, q);
      if (vecs[i].chk) check($sformatf("vec%0d_data", i), q, vecs[i].exp);
    end
    sh_m[3] = 16'h1234; sh_m[31] = 16'hBEEF;
    check_conf("t1_conf_before_commit");

    // 1: COMMIT with engine idle takes effect one edge after acceptance
    host(0, 6'd33, 0, q);
    check("t1_commit_done_early", commit_done, 0);
    @(negedge clk);
    check("t1_commit_done", commit_done, 1);
    act_m = sh_m;
    check_conf("t1_conf_after_commit");
    @(negedge clk);
    check("t1_commit_done_pulse", commit_done, 0);

    // 2: COMMIT blocked by engine_busy, shadow write during wait is included
    engine_busy = 1'b1;
    host(0, 6'd33, 0, q);
    repeat (3) @(negedge clk);
    check("t2_no_commit", commit_done, 0);
    host(1, 6'd36, 0, q);
    check("t2_status_pending", q, 2);
    host(0, 6'd0, 32'h5, q);
    sh_m[0] = 16'h5;
    check_conf("t2_conf_held");
    engine_busy = 1'b0;
    @(negedge clk);
    check("t2_commit_done", commit_done, 1);
    act_m = sh_m;
    check_conf("t2_conf_after");
    host(1, 6'd36, 0, q);
    check("t2_status_clear", q, 0);

    // 3: SAVE slot 2, CLEAR, LOAD slot 2
    for (int k = 0; k < NF; k++) begin
      host(0, 6'(k), 32'(k + 1), q);
      sh_m[k] = 16'(k + 1);
    end
    host(0, 6'd34, 32'd2, q);
    for (int k = 0; k < NF; k++) begin
      check($sformatf("t3_save_cyc%0d", k), {ready, cm_en, cm_we, cm_addr, cm_wdata},
            {1'b0, 1'b1, 1'b1, 3'd2, 5'(k), 16'(k + 1)});
      @(negedge clk);
    end
    check("t3_save_end", {ready, cm_en}, 2'b10);
    bad = 0;
    for (int k = 0; k < NF; k++) if (mem[2*NF + k] !== 16'(k + 1)) bad++;
    check("t3_save_mem_bad_fields", bad, 0);
    host(0, 6'd32, 0, q);
    for (int k = 0; k < NF; k++) sh_m[k] = '0;
    host(1, 6'd5, 0, q);
    check("t3_clear_f5", q, 0);
    host(0, 6'd35, 32'd2, q);
    n = 0;
    while (!ready && n < 100) begin n++; @(negedge clk); end
    check("t3_load_busy_cycles", n, 33);
    for (int k = 0; k < NF; k++) sh_m[k] = mem[2*NF + k];
    for (int k = 0; k < NF; k++) begin
      host(1, 6'(k), 0, q);
      check($sformatf("t3_load_f%0d", k), q, DW'(sh_m[k]));
    end

    // 4: pending COMMIT during LOAD is deferred until the FSM is idle again
    for (int k = 0; k < NF; k++) begin
      rv[k] = 16'($urandom);
      host(0, 6'(k), DW'(rv[k]), q);
    end
    host(0, 6'd34, 32'd5, q);
    host(0, 6'd32, 0, q);
    engine_busy = 1'b1;
    host(0, 6'd33, 0, q);
    host(0, 6'd35, 32'd5, q);
    engine_busy = 1'b0;
    n = 0; bad = 0;
    while (!ready && n < 100) begin
      if (commit_done) bad++;
      n++;
      @(negedge clk);
    end
    check("t4_commit_during_load", bad, 0);
    check("t4_first_idle_no_commit", commit_done, 0);
    check_conf("t4_conf_old");
    @(negedge clk);
    check("t4_commit_done", commit_done, 1);
    act_m = rv;
    sh_m  = rv;
    check_conf("t4_conf_loaded");

    // 5: held request during SAVE is not acked; reset mid-SAVE aborts
    host(0, 6'd34, 32'd1, q);
    req = 1'b1; rnw = 1'b0; addr = 6'd1; data_in = 32'h7777;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (ack || ready) bad++;
    end
    check("t5_no_ack_while_busy", bad, 0);
    req = 1'b0;
    rst = 1'b1;
    #1;
    for (int k = 0; k < NF; k++) begin sh_m[k] = '0; act_m[k] = '0; end
    pend_m = 1'b0;
    check("t5_rst_cm_en", cm_en, 0);
    check("t5_rst_ready", ready, 1);
    check_conf("t5_rst_conf");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); @(negedge clk);
    check("t5_cm_en_after", cm_en, 0);
    host(1, 6'd1, 0, q);
    check("t5_f1_zero", q, 0);
    host(1, 6'd7, 0, q);
    check("t5_f7_zero", q, 0);

    // 6: CLEAR leaves active untouched; unmapped address
    for (int k = 0; k < 4; k++) begin
      host(0, 6'(k), 32'hA0 + 32'(k), q);
      sh_m[k] = 16'hA0 + 16'(k);
    end
    host(0, 6'd33, 0, q);
    @(negedge clk);
    act_m = sh_m;
    check_conf("t6_conf_committed");
    host(0, 6'd32, 0, q);
    for (int k = 0; k < NF; k++) sh_m[k] = '0;
    host(1, 6'd2, 0, q);
    check("t6_clear_f2", q, 0);
    check_conf("t6_conf_kept");
    host(1, 6'd37, 0, q);
    check("t6_addr37", q, 0);

    // Randomized host traffic against the model
    for (int it = 0; it < 200; it++) begin
      int kind;
      int a;
      int op;
      bit r;
      bit fire;
      logic [DW-1:0] d;
      logic [DW-1:0] expq;
      logic [AW-1:0] ha;
      engine_busy = ($urandom_range(0, 3) == 0);
      kind = $urandom_range(0, 9);
      d = $urandom;
      a = $urandom_range(0, NF - 1);
      op = 0; r = 1'b1; expq = '0; ha = 6'(a);
      case (kind)
        0, 1, 2: begin op = 1; r = 1'b0; end
        3, 4, 5: begin expq = DW'(sh_m[a]); end
        6: begin ha = 6'd36; expq = DW'({pend_m, 1'b0}); end
        7: begin op = 2; r = 1'b0; ha = 6'd32; end
        8: begin
          if (!pend_m || engine_busy) begin op = 3; r = 1'b0; ha = 6'd33; end
          else begin ha = 6'($urandom_range(37, 63)); end
        end
        default: begin ha = 6'($urandom_range(37, 63)); end
      endcase
      host(r, ha, d, q);
      fire = model_edge(op, a, d[FW-1:0]);
      if (r) check($sformatf("rnd%0d_read_a%0d", it, ha), q, expq);
      check($sformatf("rnd%0d_commit_done_t", it), commit_done, fire);
      fire = model_edge(0, 0, '0);
      @(negedge clk);
      check($sformatf("rnd%0d_commit_done_t1", it), commit_done, fire);
      check_conf($sformatf("rnd%0d_conf", it));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
